// File: rtl/sd_pkg.sv
// Shared definitions for the SD-card SPI engine: FSM states, canned
// command frames, response lengths, divider codes and small helpers.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DUMMY = 3'd1,
    ST_CMD   = 3'd2,
    ST_POLL  = 3'd3,
    ST_RESP  = 3'd4,
    ST_TAIL  = 3'd5,
    ST_DONE  = 3'd6
  } sd_state_t;

  localparam logic [47:0] CMD0  = 48'h400000000095;
  localparam logic [47:0] CMD8  = 48'h48000001AA87;
  localparam logic [47:0] CMD55 = 48'h770000000001;
  localparam logic [47:0] CMD58 = 48'h7A0000000001;

  localparam logic [2:0] RESP_R1 = 3'd1;
  localparam logic [2:0] RESP_R3 = 3'd5;
  localparam logic [2:0] RESP_R7 = 3'd5;

  localparam logic [1:0] DIV_SLOW = 2'd3;
  localparam logic [1:0] DIV_FAST = 2'd0;

  // Mirror a frame so an LSB-first transfer can reuse the MSB-first shifter.
  function automatic logic [47:0] bit_reverse48(input logic [47:0] v);
    logic [47:0] r;
    r = 48'd0;
    for (int i = 0; i < 48; i++) begin
      r[i] = v[47-i];
    end
    return r;
  endfunction

  // Response length is 1..6 bytes; 0 means one byte, anything above 6 means six.
  function automatic logic [2:0] clamp_resp_len(input logic [2:0] len);
    logic [2:0] r;
    if (len == 3'd0) begin
      r = 3'd1;
    end else if (len > 3'd6) begin
      r = 3'd6;
    end else begin
      r = len;
    end
    return r;
  endfunction

endpackage

// File: rtl/sd_spi_clkgen.sv
// SCK generator: half-period of 4^div system cycles while enabled, always
// starting with a low half. Strobes mark the cycle in which SCK toggles.
module sd_spi_clkgen
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] div,
  output logic       sck,
  output logic       rise_tick,
  output logic       fall_tick
);

  logic [5:0] cnt_r;
  logic [5:0] half_m1_s;
  logic       sck_r;
  logic       wrap_s;

  // Terminal count of the half-period counter for the selected divider.
  always_comb begin
    half_m1_s = 6'd63;
    case (div)
      2'd0:    half_m1_s = 6'd0;
      2'd1:    half_m1_s = 6'd3;
      2'd2:    half_m1_s = 6'd15;
      default: half_m1_s = 6'd63;
    endcase
  end

  // Half-period counter and SCK register; idle parks SCK low with a fresh count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 6'd0;
      sck_r <= 1'b0;
    end else if (!en) begin
      cnt_r <= 6'd0;
      sck_r <= 1'b0;
    end else if (cnt_r == half_m1_s) begin
      cnt_r <= 6'd0;
      sck_r <= ~sck_r;
    end else begin
      cnt_r <= cnt_r + 6'd1;
    end
  end

  assign wrap_s    = en && (cnt_r == half_m1_s);
  assign rise_tick = wrap_s && !sck_r;
  assign fall_tick = wrap_s && sck_r;
  assign sck       = sck_r;

endmodule

// File: rtl/sd_spi_master.sv
// SPI mode-0 command engine for an SD card: sends a 48-bit frame, polls for
// the first non-0xFF byte, captures 1..6 response bytes, then clocks a tail
// with CS high. A dummy request clocks the power-up dummy cycles instead.
module sd_spi_master
  import sd_pkg::*;
#(
  parameter int NCR_MAX    = 8,
  parameter int DUMMY_CLKS = 80,
  parameter int TAIL_CLKS  = 8
) (
  input  logic        spi_clk_i,
  input  logic        spi_rst_i,
  input  logic        spi_start_i,
  input  logic        spi_dummy_i,
  input  logic        spi_fbo_i,
  input  logic [1:0]  spi_div_i,
  input  logic [47:0] spi_cmd_i,
  input  logic [2:0]  spi_resp_len_i,
  input  logic        spi_miso_i,
  output logic        spi_sck_o,
  output logic        spi_mosi_o,
  output logic        spi_cs_n_o,
  output logic [47:0] spi_data_o,
  output logic        spi_done_o,
  output logic        spi_busy_o,
  output logic        spi_timeout_o
);

  sd_state_t   state_r, state_nxt;
  logic [1:0]  div_r;
  logic [2:0]  len_r;
  logic [46:0] shift_r;
  logic [6:0]  bit_cnt;
  logic [7:0]  poll_cnt;
  logic [2:0]  byte_cnt;
  logic [7:0]  rx_byte;
  logic [47:0] data_r;
  logic        mosi_r, cs_n_r, done_r, busy_r, timeout_r;
  logic        clk_en, rise_tick, fall_tick;
  logic        byte_end, resp_hit, poll_last, resp_last, count_last;
  logic [47:0] cmd_ord;

  sd_spi_clkgen u_clkgen (
    .clk       (spi_clk_i),
    .rst       (spi_rst_i),
    .en        (clk_en),
    .div       (div_r),
    .sck       (spi_sck_o),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // Next-state decode plus the shared end-of-bit/byte conditions.
  always_comb begin
    state_nxt  = state_r;
    clk_en     = (state_r == ST_DUMMY) || (state_r == ST_CMD) || (state_r == ST_POLL) ||
                 (state_r == ST_RESP)  || (state_r == ST_TAIL);
    byte_end   = fall_tick && (bit_cnt[2:0] == 3'd7);
    resp_hit   = (rx_byte != 8'hFF);
    poll_last  = (poll_cnt == 8'(NCR_MAX - 1));
    resp_last  = ((byte_cnt + 3'd1) == len_r);
    count_last = ((state_r == ST_DUMMY) && (bit_cnt == 7'(DUMMY_CLKS - 1))) ||
                 ((state_r == ST_TAIL)  && (bit_cnt == 7'(TAIL_CLKS - 1)));
    cmd_ord    = spi_fbo_i ? bit_reverse48(spi_cmd_i) : spi_cmd_i;
    case (state_r)
      ST_IDLE: begin
        if (spi_start_i) begin
          state_nxt = spi_dummy_i ? ST_DUMMY : ST_CMD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      // Dummy clocks run straight into the tail, which is electrically identical.
      ST_DUMMY, ST_TAIL: begin
        if (fall_tick && count_last) begin
          state_nxt = (state_r == ST_DUMMY) ? ST_TAIL : ST_DONE;
        end else begin
          state_nxt = state_r;
        end
      end
      ST_CMD: begin
        if (fall_tick && (bit_cnt == 7'd47)) begin
          state_nxt = ST_POLL;
        end else begin
          state_nxt = ST_CMD;
        end
      end
      ST_POLL: begin
        if (byte_end && resp_hit) begin
          state_nxt = (len_r == 3'd1) ? ST_TAIL : ST_RESP;
        end else if (byte_end && poll_last) begin
          state_nxt = ST_TAIL;
        end else begin
          state_nxt = ST_POLL;
        end
      end
      ST_RESP: begin
        if (byte_end && resp_last) begin
          state_nxt = ST_TAIL;
        end else begin
          state_nxt = ST_RESP;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge spi_clk_i) begin
    if (spi_rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Datapath: command shifter, bit/byte counters, response capture and pin registers.
  always_ff @(posedge spi_clk_i) begin
    if (spi_rst_i) begin
      div_r     <= 2'd0;
      len_r     <= 3'd0;
      shift_r   <= 47'd0;
      bit_cnt   <= 7'd0;
      poll_cnt  <= 8'd0;
      byte_cnt  <= 3'd0;
      rx_byte   <= 8'd0;
      data_r    <= 48'd0;
      mosi_r    <= 1'b1;
      cs_n_r    <= 1'b1;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      done_r <= (state_nxt == ST_DONE);
      busy_r <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
      cs_n_r <= !((state_nxt == ST_CMD) || (state_nxt == ST_POLL) || (state_nxt == ST_RESP));
      case (state_r)
        ST_IDLE: begin
          if (spi_start_i) begin
            div_r     <= spi_div_i;
            len_r     <= clamp_resp_len(spi_resp_len_i);
            timeout_r <= 1'b0;
            bit_cnt   <= 7'd0;
            poll_cnt  <= 8'd0;
            byte_cnt  <= 3'd0;
            rx_byte   <= 8'd0;
            if (spi_dummy_i) begin
              data_r <= {48{1'b1}};
              mosi_r <= 1'b1;
            end else begin
              data_r  <= 48'd0;
              mosi_r  <= cmd_ord[47];
              shift_r <= cmd_ord[46:0];
            end
          end
        end
        ST_DUMMY, ST_TAIL: begin
          if (fall_tick) begin
            bit_cnt <= count_last ? 7'd0 : bit_cnt + 7'd1;
          end
        end
        ST_CMD: begin
          if (fall_tick) begin
            if (bit_cnt == 7'd47) begin
              bit_cnt <= 7'd0;
              mosi_r  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 7'd1;
              mosi_r  <= shift_r[46];
              shift_r <= {shift_r[45:0], 1'b0};
            end
          end
        end
        ST_POLL, ST_RESP: begin
          if (rise_tick) begin
            rx_byte <= {rx_byte[6:0], spi_miso_i};
          end
          if (fall_tick) begin
            bit_cnt <= byte_end ? 7'd0 : bit_cnt + 7'd1;
          end
          if (byte_end) begin
            if (state_r == ST_POLL) begin
              if (resp_hit) begin
                data_r   <= {40'd0, rx_byte};
                byte_cnt <= 3'd1;
              end else if (poll_last) begin
                data_r    <= {48{1'b1}};
                timeout_r <= 1'b1;
              end else begin
                poll_cnt <= poll_cnt + 8'd1;
              end
            end else begin
              data_r   <= {data_r[39:0], rx_byte};
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign spi_mosi_o    = mosi_r;
  assign spi_cs_n_o    = cs_n_r;
  assign spi_data_o    = data_r;
  assign spi_done_o    = done_r;
  assign spi_busy_o    = busy_r;
  assign spi_timeout_o = timeout_r;

endmodule

// File: tb/tb_sd_spi_master.sv
// Bench for sd_spi_master: directed transactions with an SD card model on the
// pins. Stimulus queues the expected outcome of each transaction; a monitor
// measures the bus and compares against the queue whenever done pulses.
module tb_sd_spi_master;
  import sd_pkg::*;

  logic        spi_clk_i = 1'b0;
  logic        spi_rst_i = 1'b1;
  logic        spi_start_i = 1'b0;
  logic        spi_dummy_i = 1'b0;
  logic        spi_fbo_i = 1'b0;
  logic [1:0]  spi_div_i = 2'd0;
  logic [47:0] spi_cmd_i = 48'd0;
  logic [2:0]  spi_resp_len_i = 3'd0;
  logic        spi_miso_i = 1'b1;
  logic        spi_sck_o, spi_mosi_o, spi_cs_n_o, spi_done_o, spi_busy_o, spi_timeout_o;
  logic [47:0] spi_data_o;

  sd_spi_master dut (
    .spi_clk_i(spi_clk_i), .spi_rst_i(spi_rst_i), .spi_start_i(spi_start_i),
    .spi_dummy_i(spi_dummy_i), .spi_fbo_i(spi_fbo_i), .spi_div_i(spi_div_i),
    .spi_cmd_i(spi_cmd_i), .spi_resp_len_i(spi_resp_len_i), .spi_miso_i(spi_miso_i),
    .spi_sck_o(spi_sck_o), .spi_mosi_o(spi_mosi_o), .spi_cs_n_o(spi_cs_n_o),
    .spi_data_o(spi_data_o), .spi_done_o(spi_done_o), .spi_busy_o(spi_busy_o),
    .spi_timeout_o(spi_timeout_o)
  );

  always #5 spi_clk_i = ~spi_clk_i;

  typedef struct {
    logic [47:0] data;
    logic        tmo;
    int          cs_lo;   // SCK rising edges with CS low
    int          cs_hi;   // SCK rising edges with CS high
    logic        is_cmd;
    logic [47:0] stream;  // MOSI bits in transmission order, first bit at [47]
    int          hi;      // SCK high phase in system cycles
  } exp_t;

  exp_t exp_q[$];
  logic bits_q[$];
  int   checks = 0;
  int   errors = 0;
  logic end_req = 1'b0;

  logic        prev_sck = 1'b0, prev_cs = 1'b1, prev_rst = 1'b0, prev_done = 1'b0;
  int          cmd_bits = 0, cs_lo = 0, cs_hi = 0, mosi_bad = 0, hi_cnt = 0;
  int          hi_min = 9999, hi_max = 0;
  logic [47:0] cap = 48'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Monitor + card model: sampled on the falling system-clock edge.
  always @(negedge spi_clk_i) begin
    exp_t e;
    if (spi_rst_i || prev_rst) begin
      if (prev_rst) begin
        check("rst_sck", 64'(spi_sck_o), 64'd0);
        check("rst_mosi", 64'(spi_mosi_o), 64'd1);
        check("rst_cs_n", 64'(spi_cs_n_o), 64'd1);
        check("rst_data", 64'(spi_data_o), 64'd0);
        check("rst_done", 64'(spi_done_o), 64'd0);
        check("rst_busy", 64'(spi_busy_o), 64'd0);
        check("rst_timeout", 64'(spi_timeout_o), 64'd0);
      end
      cmd_bits = 0; cs_lo = 0; cs_hi = 0; mosi_bad = 0;
      hi_cnt = 0; hi_min = 9999; hi_max = 0;
      spi_miso_i = 1'b1;
    end else begin
      if (prev_cs && !spi_cs_n_o) cmd_bits = 0;
      if (spi_sck_o) hi_cnt++;
      if (spi_sck_o && !prev_sck) begin
        if (!spi_cs_n_o) begin
          cs_lo++;
          if (cmd_bits < 48) begin
            cap = {cap[46:0], spi_mosi_o};
            cmd_bits++;
          end
        end else begin
          cs_hi++;
          if (!spi_mosi_o) mosi_bad++;
        end
      end
      if (!spi_sck_o && prev_sck) begin
        if (hi_cnt < hi_min) hi_min = hi_cnt;
        if (hi_cnt > hi_max) hi_max = hi_cnt;
        hi_cnt = 0;
        // Card shifts its next bit out on the falling edge once the frame is in.
        if (!spi_cs_n_o && cmd_bits == 48) begin
          if (bits_q.size() > 0) spi_miso_i = bits_q.pop_front();
          else spi_miso_i = 1'b1;
        end
      end
      if (prev_done) check("done_width", 64'(spi_done_o), 64'd0);
      if (spi_done_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done with no transaction outstanding");
        end else begin
          e = exp_q.pop_front();
          check("data", 64'(spi_data_o), 64'(e.data));
          check("timeout", 64'(spi_timeout_o), 64'(e.tmo));
          check("sck_cs_low", 64'(cs_lo), 64'(e.cs_lo));
          check("sck_cs_high", 64'(cs_hi), 64'(e.cs_hi));
          if (e.is_cmd) check("mosi_stream", 64'(cap), 64'(e.stream));
          check("sck_high_min", 64'(hi_min), 64'(e.hi));
          check("sck_high_max", 64'(hi_max), 64'(e.hi));
          check("busy_at_done", 64'(spi_busy_o), 64'd0);
          check("mosi_low_cs_high", 64'(mosi_bad), 64'd0);
        end
        cs_lo = 0; cs_hi = 0; mosi_bad = 0; hi_min = 9999; hi_max = 0;
      end
    end
    if (end_req) begin
      check("pending_txns", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
    prev_sck  = spi_sck_o;
    prev_cs   = spi_cs_n_o;
    prev_rst  = spi_rst_i;
    prev_done = spi_done_o;
  end

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bits_q.push_back(b[i]);
  endtask

  task automatic issue(input logic dummy, input logic fbo, input logic [1:0] div,
                       input logic [47:0] cmd, input logic [2:0] len);
    @(posedge spi_clk_i); #1;
    spi_dummy_i = dummy; spi_fbo_i = fbo; spi_div_i = div;
    spi_cmd_i = cmd; spi_resp_len_i = len; spi_start_i = 1'b1;
    @(posedge spi_clk_i); #1;
    spi_start_i = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20000; i++) begin
      @(posedge spi_clk_i); #1;
      if (spi_done_o) break;
    end
  endtask

  // Stimulus: directed transactions with hand-computed expectations.
  initial begin
    repeat (3) @(posedge spi_clk_i);
    #1 spi_rst_i = 1'b0;

    // Dummy clocks at div 0: 80 + 8 tail edges, all with CS and MOSI high.
    exp_q.push_back('{data: 48'hFFFFFFFFFFFF, tmo: 1'b0, cs_lo: 0, cs_hi: 88,
                      is_cmd: 1'b0, stream: 48'd0, hi: 1});
    issue(1'b1, 1'b0, DIV_FAST, 48'd0, RESP_R1);
    wait_done();

    // CMD0 at the slow divider, R1 = 0x01 after two poll bytes.
    bits_q.delete();
    push_byte(8'hFF); push_byte(8'hFF); push_byte(8'h01);
    exp_q.push_back('{data: 48'h000000000001, tmo: 1'b0, cs_lo: 72, cs_hi: 8,
                      is_cmd: 1'b1, stream: 48'h400000000095, hi: 64});
    issue(1'b0, 1'b0, DIV_SLOW, CMD0, RESP_R1);
    wait_done();

    // CMD8 with R7; a start pulse mid-transaction must be ignored.
    bits_q.delete();
    push_byte(8'hFF); push_byte(8'h01); push_byte(8'h00);
    push_byte(8'h00); push_byte(8'h01); push_byte(8'hAA);
    exp_q.push_back('{data: 48'h0001000001AA, tmo: 1'b0, cs_lo: 96, cs_hi: 8,
                      is_cmd: 1'b1, stream: 48'h48000001AA87, hi: 1});
    issue(1'b0, 1'b0, DIV_FAST, CMD8, RESP_R7);
    repeat (50) @(posedge spi_clk_i);
    issue(1'b1, 1'b0, DIV_SLOW, CMD0, RESP_R1);
    wait_done();

    // No response: eight 0xFF poll bytes, then timeout with all-ones data.
    bits_q.delete();
    exp_q.push_back('{data: 48'hFFFFFFFFFFFF, tmo: 1'b1, cs_lo: 112, cs_hi: 8,
                      is_cmd: 1'b1, stream: 48'h770000000001, hi: 1});
    issue(1'b0, 1'b0, DIV_FAST, CMD55, RESP_R1);
    wait_done();

    // LSB-first frame of value 1; resp_len 0 acts as one byte; timeout clears.
    bits_q.delete();
    push_byte(8'h00);
    exp_q.push_back('{data: 48'h000000000000, tmo: 1'b0, cs_lo: 56, cs_hi: 8,
                      is_cmd: 1'b1, stream: 48'h800000000000, hi: 16});
    issue(1'b0, 1'b1, 2'd2, 48'h000000000001, 3'd0);
    wait_done();

    // Reset in the middle of a command: abandoned without a done pulse.
    bits_q.delete();
    issue(1'b0, 1'b0, DIV_SLOW, CMD58, RESP_R3);
    repeat (300) @(posedge spi_clk_i);
    #1 spi_rst_i = 1'b1;
    @(posedge spi_clk_i); #1 spi_rst_i = 1'b0;
    repeat (20) @(posedge spi_clk_i);

    // Fresh CMD58 at div 1; 0xFF inside the response is data, not polling.
    bits_q.delete();
    push_byte(8'h00); push_byte(8'h80); push_byte(8'hFF);
    push_byte(8'h80); push_byte(8'h00);
    exp_q.push_back('{data: 48'h000080FF8000, tmo: 1'b0, cs_lo: 88, cs_hi: 8,
                      is_cmd: 1'b1, stream: 48'h7A0000000001, hi: 4});
    issue(1'b0, 1'b0, 2'd1, CMD58, RESP_R3);
    wait_done();

    // resp_len 7 is clamped to six bytes, filling the whole word.
    bits_q.delete();
    push_byte(8'hFF); push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    push_byte(8'h44); push_byte(8'h55); push_byte(8'h66);
    exp_q.push_back('{data: 48'h112233445566, tmo: 1'b0, cs_lo: 104, cs_hi: 8,
                      is_cmd: 1'b1, stream: 48'h400000000095, hi: 1});
    issue(1'b0, 1'b0, DIV_FAST, CMD0, 3'd7);
    wait_done();

    repeat (5) @(posedge spi_clk_i);
    end_req = 1'b1;
    repeat (20) @(posedge spi_clk_i);
    $display("FAIL end_of_test: monitor did not conclude");
    $fatal(1, "bench did not conclude");
  end

endmodule
